// File: rtl/divider_checker_if.sv
// Divided-clock checker bus: clock/flag under test in,
// period measurements and lock/error status out.
interface divider_checker_if #(
    parameter int CNT_W = 8
);
    logic             clk_in;
    logic             clk_flag_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output clk_in,
        output clk_flag_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  locked,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  clk_in,
        input  clk_flag_in,
        output period,
        output high_time,
        output period_valid,
        output locked,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/divider_checker.sv
// Divided-clock checker: measures period/high time of clk_in,
// locks after LOCK_CNT good periods and flags errors once locked.
module divider_checker #(
    parameter int DIV_EXP  = 5,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    divider_checker_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP     = CNT_W'(DIV_EXP);
    localparam logic [3:0]       LOCK    = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic             clk_d_q, clk_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             rise;
    logic [1:0]       fcnt_close;
    logic             good;
    logic             timeout;

    // Next-state: edge detect, counters, lock FSM and status strobes
    always_comb begin
        rise       = bus.clk_in & ~clk_d_q;
        // a flag coincident with the rise belongs to the closing period
        fcnt_close = (bus.clk_flag_in && fcnt_q != 2'd3) ? fcnt_q + 2'd1 : fcnt_q;
        good       = (cnt_q == EXP) && (fcnt_close == 2'd1);
        // fires on the edge where cnt saturates
        timeout    = !rise && (state_q != IDLE) && (cnt_q == CNT_MAX - ONE);

        state_d   = state_q;
        clk_d_d   = bus.clk_in;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        fcnt_d    = fcnt_q;
        gcnt_d    = gcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        pv_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (rise) begin
            cnt_d  = ONE;
            hcnt_d = ONE;
            fcnt_d = 2'd0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
            if (bus.clk_in && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + ONE;
            fcnt_d = fcnt_close;
        end

        unique case (state_q)
            IDLE: begin
                gcnt_d = 4'd0;
                if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    pv_d     = 1'b1;
                    if (good) begin
                        gcnt_d = gcnt_q + 4'd1;
                        if (gcnt_q + 4'd1 == LOCK) state_d = LOCKED;
                    end else begin
                        gcnt_d = 4'd0;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    gcnt_d  = 4'd0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    pv_d     = 1'b1;
                    if (!good) begin
                        err_d   = 1'b1;
                        gcnt_d  = 4'd0;
                        state_d = MEASURE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    gcnt_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            clk_d_q   <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            fcnt_q    <= 2'd0;
            gcnt_q    <= 4'd0;
            period_q  <= '0;
            high_q    <= '0;
            pv_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            clk_d_q   <= clk_d_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            fcnt_q    <= fcnt_d;
            gcnt_q    <= gcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            pv_q      <= pv_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.high_time    = high_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = locked_q;
    assign bus.err          = err_q;
    assign bus.err_cnt      = err_cnt_q;
endmodule
